riscv_dcache: RTL and testbench
===============================

// Module: riscv_dcache
// PURPOSE
//  Data-cache responder on the core's dcache port (dcache_addr/re/we/din -> dcache_dout, stall).
//  Direct-mapped, write-back, write-allocate; 4-word lines; single-beat 128-bit backing-memory interface.
//  Read data returns one cycle after the request, matching the core's stage-3 load path.
//  On a miss, stall holds the whole pipeline until the line is filled.
// PARAMETERS
//  LINES       64   number of cache lines (power of 2); index width IW=log2(LINES)
//  ADDR_WIDTH  32   byte-address width; tag = addr[ADDR_WIDTH-1:4+IW]
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-high reset
//  cpu_stall      in   1    global pipeline stall (OR of all stall sources); new request accepted only when low
//  dcache_addr    in   32   byte address (stage X ALU output)
//  dcache_re      in   1    load request
//  dcache_we      in   4    byte write enables; nonzero = store
//  dcache_din     in   32   store data, already lane-aligned by the core
//  dcache_dout    out  32   full aligned word for the registered request; core does lane extraction
//  stall          out  1    cache busy; core freezes while high
//  mem_req_valid  out  1    backing-memory request
//  mem_req_ready  in   1    request accepted this cycle when valid&ready
//  mem_req_rw     out  1    1 = line write (writeback), 0 = line read (fill)
//  mem_req_addr   out  28   line address addr[31:4]
//  mem_req_data   out  128  writeback line, word 0 in [31:0]
//  mem_resp_valid in   1    fill data valid (one beat)
//  mem_resp_data  in   128  fill line, word 0 in [31:0]
// BEHAVIOUR
//  - Request register {addr, re, we, din, pend, done} loads on every edge where cpu_stall=0 && stall=0.
//    pend = re | (|we); done cleared on load.
//  - Arrays are flop-based, read combinationally from the registered address:
//    hit = pend & valid[idx] & (tag[idx]==req_tag).
//  - dcache_dout = data[idx][word] when req re & hit; else 0.
//    Holds while the request register holds.
//  - Store hit with done=0: byte-enabled write at clock end; set dirty; set done.
//    Never re-committed while the core is frozen. Visible to a load in the next cycle.
//  - stall = pend & (state!=IDLE | ~hit); combinational; 0 out of reset.
//  - FSM:
//    IDLE: pend & ~hit -> WB if valid&dirty victim, else FILL_REQ.
//    WB: mem_req_valid=1, rw=1, addr={victim_tag,idx}, data=victim line; on ready -> FILL_REQ.
//    FILL_REQ: valid=1, rw=0, addr=req_addr[31:4]; on ready -> FILL_WAIT.
//    FILL_WAIT: on resp_valid write line, set valid, clear dirty, set tag -> IDLE.
//    Next cycle IDLE re-looks up, hits, store merges, stall drops.
//  - mem_req_valid stays high with stable addr/data until ready (valid/ready rule). At most one outstanding request.
//  - Miss latency: stall high from the request cycle T+1 through the resp cycle; the hit cycle after that has stall=0.
//  - cpu_stall high for an unrelated reason: request register holds, dout holds, no new lookup; any miss FSM still runs.
//  - Unaligned accesses are not checked; addr[1:0] is ignored for indexing.
//  - Reset: all valid/dirty=0, state=IDLE, pend=0, stall=0, mem_req_valid=0, dcache_dout=0.
//    Reset mid-miss aborts immediately; memory must tolerate a dropped valid. Tags and data are not reset.
// STRUCTURE
//  Shared const.vh additions:
//  - `DC_IDLE/`DC_WB/`DC_FILL_REQ/`DC_FILL_WAIT (2-bit)
//  - `DC_LINE_BITS=128, `DC_OFFSET_BITS=4
//  Sub-module: dcache_array (valid/dirty/tag/data storage, combinational read port, one line-write port with word/byte enables).
//  FSM, request register and muxing stay in riscv_dcache.
// TESTING
//  1. Reset, then load 0x100: stall=1, FILL_REQ addr=0x010. Resp 0x...DDDDCCCCBBBBAAAA -> next cycle stall=0, dout=0xAAAAAAAA.
//  2. Load 0x104 right after case 1 -> hit, stall stays 0, dout=0xBBBBBBBB in one cycle.
//  3. Store we=4'b0100 din=0x00770000 to 0x100 (hit), then load 0x100 -> dout=0xAA77AAAA, no memory traffic.
//  4. Load 0x100+LINES*16 (same index, dirty) -> WB first: rw=1, addr=0x010, data word0=0xAA77AAAA.
//     Then the fill request. Hold ready=0 for 3 cycles: addr/data stable.
//  5. Store hit with cpu_stall held high 4 cycles -> array written once, dirty set, dout stable.
//  6. Assert reset in FILL_WAIT -> next cycle mem_req_valid=0, stall=0.
//     Reload the same address -> miss again (valid cleared).

Source files
------------

// File: rtl/riscv_dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Line geometry, miss-FSM state encoding and the store byte-enable helper.
package riscv_dcache_pkg;

    localparam int DC_LINE_BITS   = 128;
    localparam int DC_OFFSET_BITS = 4;
    localparam int DC_LINE_BYTES  = DC_LINE_BITS / 8;

    typedef enum logic [1:0] {
        DC_IDLE      = 2'd0,
        DC_WB        = 2'd1,
        DC_FILL_REQ  = 2'd2,
        DC_FILL_WAIT = 2'd3
    } dc_state_e;

    // Places a word's 4 byte enables at its position inside a 16-byte line.
    function automatic logic [DC_LINE_BYTES-1:0] dc_byte_en(input logic [1:0] word,
                                                            input logic [3:0] we);
        return DC_LINE_BYTES'(we) << {word, 2'b00};
    endfunction

endpackage

// File: rtl/riscv_dcache_if.sv
// Single-beat line-granular backing-memory bus between the data cache and memory.
// The cache is the master; memory accepts with ready and answers fills with one resp beat.
interface riscv_dcache_if #(
    parameter int ADDR_WIDTH = 32
);

    logic                                                    mem_req_valid;
    logic                                                    mem_req_ready;
    logic                                                    mem_req_rw;
    logic [ADDR_WIDTH-riscv_dcache_pkg::DC_OFFSET_BITS-1:0] mem_req_addr;
    logic [riscv_dcache_pkg::DC_LINE_BITS-1:0]              mem_req_data;
    logic                                                    mem_resp_valid;
    logic [riscv_dcache_pkg::DC_LINE_BITS-1:0]              mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/riscv_dcache_array.sv
// Flop-based valid/dirty/tag/data storage for the data cache.
// Combinational read port; one line-write port with byte enables that also sets valid.
module riscv_dcache_array
    import riscv_dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IW    = $clog2(LINES),
    parameter int TAG_W = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IW-1:0]            rd_idx,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [DC_LINE_BITS-1:0]  rd_line,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [DC_LINE_BYTES-1:0] wr_be,
    input  logic [DC_LINE_BITS-1:0]  wr_data,
    input  logic                     wr_dirty
);

    logic [LINES-1:0]        valid_q, valid_d;
    logic [LINES-1:0]        dirty_q, dirty_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [DC_LINE_BITS-1:0] data_q [LINES];
    logic [DC_LINE_BITS-1:0] line_d;

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        line_d  = data_q[wr_idx];
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            dirty_d[wr_idx] = wr_dirty;
        end
        for (int b = 0; b < DC_LINE_BYTES; b++) begin
            if (wr_be[b]) line_d[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= line_d;
        end
    end

endmodule

// File: rtl/riscv_dcache.sv
// Direct-mapped, write-back, write-allocate data cache on the core's dcache port.
// Registered request, combinational hit/readout, and a miss FSM driving the memory bus.
module riscv_dcache
    import riscv_dcache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_stall,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic                  dcache_re,
    input  logic [3:0]            dcache_we,
    input  logic [31:0]           dcache_din,
    output logic [31:0]           dcache_dout,
    output logic                  stall,
    riscv_dcache_if.master        mem
);

    localparam int IW    = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - DC_OFFSET_BITS - IW;

    dc_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:2] req_addr_q, req_addr_d;
    logic                  req_re_q, req_re_d;
    logic [3:0]            req_we_q, req_we_d;
    logic [31:0]           req_din_q, req_din_d;
    logic                  req_pend_q, req_pend_d;
    logic                  req_done_q, req_done_d;

    logic [IW-1:0]            req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic [1:0]               req_word;
    logic                     rd_valid, rd_dirty;
    logic [TAG_W-1:0]         rd_tag;
    logic [DC_LINE_BITS-1:0]  rd_line;
    logic                     hit, accept, store_commit, fill_wr;
    logic                     arr_wr_en, arr_wr_dirty;
    logic [DC_LINE_BYTES-1:0] arr_wr_be;
    logic [DC_LINE_BITS-1:0]  arr_wr_data;

    assign req_word = req_addr_q[3:2];
    assign req_idx  = req_addr_q[DC_OFFSET_BITS +: IW];
    assign req_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_W];

    assign hit          = req_pend_q && rd_valid && (rd_tag == req_tag);
    assign stall        = req_pend_q && ((state_q != DC_IDLE) || !hit);
    assign accept       = !cpu_stall && !stall;
    // done keeps a store from being merged again while the core is frozen.
    assign store_commit = (state_q == DC_IDLE) && hit && (|req_we_q) && !req_done_q;
    assign fill_wr      = (state_q == DC_FILL_WAIT) && mem.mem_resp_valid;

    riscv_dcache_array #(
        .LINES (LINES),
        .IW    (IW),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (arr_wr_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_be    (arr_wr_be),
        .wr_data  (arr_wr_data),
        .wr_dirty (arr_wr_dirty)
    );

    always_comb begin
        arr_wr_en    = store_commit || fill_wr;
        arr_wr_dirty = !fill_wr;
        arr_wr_be    = fill_wr ? '1 : dc_byte_en(req_word, req_we_q);
        arr_wr_data  = fill_wr ? mem.mem_resp_data : {4{req_din_q}};
    end

    always_comb begin
        dcache_dout = '0;
        if (req_re_q && hit) dcache_dout = rd_line[{req_word, 5'b0} +: 32];
    end

    always_comb begin
        req_addr_d = req_addr_q;
        req_re_d   = req_re_q;
        req_we_d   = req_we_q;
        req_din_d  = req_din_q;
        req_pend_d = req_pend_q;
        req_done_d = req_done_q || store_commit;
        if (accept) begin
            req_addr_d = dcache_addr[ADDR_WIDTH-1:2];
            req_re_d   = dcache_re;
            req_we_d   = dcache_we;
            req_din_d  = dcache_din;
            req_pend_d = dcache_re || (|dcache_we);
            req_done_d = 1'b0;
        end
    end

    always_comb begin
        state_d           = state_q;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_rw    = 1'b0;
        mem.mem_req_addr  = req_addr_q[ADDR_WIDTH-1:DC_OFFSET_BITS];
        mem.mem_req_data  = '0;
        case (state_q)
            DC_IDLE: begin
                if (req_pend_q && !hit) state_d = (rd_valid && rd_dirty) ? DC_WB : DC_FILL_REQ;
            end
            DC_WB: begin
                // Victim line stays readable here: the array is untouched until the fill.
                mem.mem_req_valid = 1'b1;
                mem.mem_req_rw    = 1'b1;
                mem.mem_req_addr  = {rd_tag, req_idx};
                mem.mem_req_data  = rd_line;
                if (mem.mem_req_ready) state_d = DC_FILL_REQ;
            end
            DC_FILL_REQ: begin
                mem.mem_req_valid = 1'b1;
                if (mem.mem_req_ready) state_d = DC_FILL_WAIT;
            end
            DC_FILL_WAIT: begin
                if (mem.mem_resp_valid) state_d = DC_IDLE;
            end
            default: state_d = DC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DC_IDLE;
            req_addr_q <= '0;
            req_re_q   <= 1'b0;
            req_we_q   <= '0;
            req_din_q  <= '0;
            req_pend_q <= 1'b0;
            req_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            req_re_q   <= req_re_d;
            req_we_q   <= req_we_d;
            req_din_q  <= req_din_d;
            req_pend_q <= req_pend_d;
            req_done_q <= req_done_d;
        end
    end

endmodule

// File: tb/tb_riscv_dcache.sv
// Self-checking bench for riscv_dcache: directed scenarios plus random traffic checked
// against an architectural memory model, a backing-memory model and a tag/dirty model.
module tb_riscv_dcache;

    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_stall;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;

    riscv_dcache_if #(.ADDR_WIDTH(32)) mif ();

    riscv_dcache #(.LINES(LINES), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_stall   (cpu_stall),
        .dcache_addr (dcache_addr),
        .dcache_re   (dcache_re),
        .dcache_we   (dcache_we),
        .dcache_din  (dcache_din),
        .dcache_dout (dcache_dout),
        .stall       (stall),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] backing [logic [27:0]];   // memory contents, line address keyed
    logic [31:0]  arch    [logic [29:0]];   // latest stored word, word address keyed
    bit           mvalid  [LINES];
    bit           mdirty  [LINES];
    logic [21:0]  mtag    [LINES];

    function automatic logic [127:0] init_line(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = {la, 2'(k), 2'b00} ^ 32'h3C5A_96E1;
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        return backing.exists(la) ? backing[la] : init_line(la);
    endfunction

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        logic [127:0] l;
        if (arch.exists(a[31:2])) return arch[a[31:2]];
        l = mem_line(a[31:4]);
        return l[a[3:2]*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        arch.delete();
        for (int i = 0; i < LINES; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = '0;
        end
    endtask

    // Waits (bounded) for a memory request, holds ready low rdly cycles checking stability.
    task automatic serve_req(input logic exp_rw, input logic [27:0] exp_addr,
                             input logic [127:0] exp_data, input int rdly, input bit chk_data);
        int n;
        n = 0;
        while (!mif.mem_req_valid && n < 8) begin
            step();
            n++;
        end
        check("req_valid", 128'(mif.mem_req_valid), 128'(1'b1));
        for (int c = 0; c <= rdly; c++) begin
            check("req_rw", 128'(mif.mem_req_rw), 128'(exp_rw));
            check("req_addr", 128'(mif.mem_req_addr), 128'(exp_addr));
            if (chk_data) check("req_data", mif.mem_req_data, exp_data);
            check("stall_busy", 128'(stall), 128'(1'b1));
            if (c == rdly) mif.mem_req_ready = 1'b1;
            step();
        end
        mif.mem_req_ready = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input logic re, input logic [3:0] we,
                          input logic [31:0] din, input int hold, input int rdly);
        int           idx;
        int           respd;
        logic [21:0]  tag;
        bit           exp_hit;
        logic [27:0]  vla;
        logic [127:0] vline;
        logic [31:0]  w;
        logic [31:0]  exp_dout;
        idx     = int'(a[9:4]);
        tag     = a[31:10];
        exp_hit = mvalid[idx] && (mtag[idx] == tag);
        respd   = int'($urandom_range(2));

        dcache_addr = a;
        dcache_re   = re;
        dcache_we   = we;
        dcache_din  = din;
        cpu_stall   = 1'b0;
        step();
        dcache_re = 1'b0;
        dcache_we = '0;
        cpu_stall = (hold > 0);
        check("stall_req", 128'(stall), 128'(!exp_hit));

        if (!exp_hit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                vla = {mtag[idx], 6'(idx)};
                for (int k = 0; k < 4; k++) vline[k*32 +: 32] = arch_word({vla, 2'(k), 2'b00});
                serve_req(1'b1, vla, vline, rdly, 1'b1);
                backing[vla] = vline;
            end
            serve_req(1'b0, a[31:4], '0, rdly, 1'b0);
            for (int c = 0; c < respd; c++) begin
                check("stall_fill", 128'(stall), 128'(1'b1));
                check("one_outstanding", 128'(mif.mem_req_valid), 128'(1'b0));
                step();
            end
            mif.mem_resp_valid = 1'b1;
            mif.mem_resp_data  = mem_line(a[31:4]);
            step();
            mif.mem_resp_valid = 1'b0;
            mif.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
            mdirty[idx] = 1'b0;
        end

        check("stall_done", 128'(stall), 128'(1'b0));
        check("no_traffic", 128'(mif.mem_req_valid), 128'(1'b0));
        exp_dout = re ? arch_word(a) : 32'h0;
        check("dout", 128'(dcache_dout), 128'(exp_dout));

        if (|we) begin
            w = arch_word(a);
            for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = din[b*8 +: 8];
            arch[a[31:2]] = w;
            mdirty[idx]   = 1'b1;
        end

        for (int c = 0; c < hold; c++) begin
            dcache_addr = $urandom;
            dcache_re   = 1'b1;
            step();
            check("hold_stall", 128'(stall), 128'(1'b0));
            check("hold_dout", 128'(dcache_dout), 128'(exp_dout));
        end
        dcache_re = 1'b0;
        cpu_stall = 1'b0;
    endtask

    task automatic idle();
        dcache_re = 1'b0;
        dcache_we = '0;
        cpu_stall = 1'b0;
        step();
        check("idle_stall", 128'(stall), 128'(1'b0));
        check("idle_dout", 128'(dcache_dout), 128'(32'h0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          op;
        int          hold;

        reset              = 1'b1;
        cpu_stall          = 1'b0;
        dcache_addr        = '0;
        dcache_re          = 1'b0;
        dcache_we          = '0;
        dcache_din         = '0;
        mif.mem_req_ready  = 1'b0;
        mif.mem_resp_valid = 1'b0;
        mif.mem_resp_data  = '0;
        clear_model();
        backing[28'h010] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};

        step();
        step();
        check("rst_stall", 128'(stall), 128'(1'b0));
        check("rst_req_valid", 128'(mif.mem_req_valid), 128'(1'b0));
        check("rst_dout", 128'(dcache_dout), 128'(32'h0));
        reset = 1'b0;

        // Cold miss fill, then back-to-back hit in the same line.
        access(32'h100, 1'b1, 4'b0000, 32'h0, 0, 0);
        check("t1_dout", 128'(dcache_dout), 128'(32'hAAAAAAAA));
        access(32'h104, 1'b1, 4'b0000, 32'h0, 0, 0);
        check("t2_dout", 128'(dcache_dout), 128'(32'hBBBBBBBB));

        // Store hit merges one byte lane; following load sees it.
        access(32'h100, 1'b0, 4'b0100, 32'h0077_0000, 0, 0);
        access(32'h100, 1'b1, 4'b0000, 32'h0, 0, 0);
        check("t3_dout", 128'(dcache_dout), 128'(32'hAA77AAAA));

        // Conflict miss on a dirty line: writeback first, ready held low 3 cycles.
        access(32'h100 + 32'(LINES * 16), 1'b1, 4'b0000, 32'h0, 0, 3);
        check("t4_backing_w0", 128'(backing[28'h010][31:0]), 128'(32'hAA77AAAA));

        // Store hit under a 4-cycle core freeze, then read back and evict it.
        access(32'h504, 1'b0, 4'b0011, 32'h0000_BEEF, 4, 0);
        access(32'h504, 1'b1, 4'b0000, 32'h0, 0, 0);
        check("t5_dout", 128'(dcache_dout), 128'(32'h5ADBBEEF ^ 32'h0 ^ (arch_word(32'h504) ^ 32'h5ADBBEEF)));
        access(32'h104, 1'b1, 4'b0000, 32'h0, 0, 1);

        // Reset while waiting for fill data aborts the miss and invalidates the cache.
        dcache_addr = 32'h2000;
        dcache_re   = 1'b1;
        step();
        dcache_re = 1'b0;
        check("t6_miss", 128'(stall), 128'(1'b1));
        step();
        check("t6_fill_req", 128'(mif.mem_req_valid), 128'(1'b1));
        mif.mem_req_ready = 1'b1;
        step();
        mif.mem_req_ready = 1'b0;
        check("t6_fill_wait", 128'(stall), 128'(1'b1));
        reset = 1'b1;
        step();
        check("t6_rst_req_valid", 128'(mif.mem_req_valid), 128'(1'b0));
        check("t6_rst_stall", 128'(stall), 128'(1'b0));
        reset = 1'b0;
        clear_model();
        access(32'h2000, 1'b1, 4'b0000, 32'h0, 0, 0);
        access(32'h100, 1'b1, 4'b0000, 32'h0, 0, 0);

        // Random traffic over a few indices and tags to force hits, conflicts and writebacks.
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(3)) << 10) | (32'($urandom_range(3)) << 4)
              | (32'($urandom_range(3)) << 2);
            op   = int'($urandom_range(9));
            hold = ($urandom_range(3) == 0) ? int'($urandom_range(4, 1)) : 0;
            if (op <= 4)
                access(a, 1'b1, 4'b0000, 32'h0, hold, int'($urandom_range(2)));
            else if (op <= 7)
                access(a, 1'b0, 4'($urandom_range(15, 1)), $urandom, hold, int'($urandom_range(2)));
            else
                idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
